bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
- Sequential arbiter and transaction sequencer for the RIB bus. It replaces the combinational fixed-priority grant with a round-robin, transaction-locked grant.
- It sits between the four bus masters (core data, core instruction, jtag, other) and the bus mux. It produces the grant index that steers the mux, a slave select decoded from the granted address, and per-master completion/error pulses.
- A timeout counter prevents a hung slave from locking the bus.

Parameters:
- NUM_SLAVES, 6: number of decodable slaves; slave index >= NUM_SLAVES is an error.
- TIMEOUT, 16: max cycles in BUSY without s_ack_i before an error completion (2..255).
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- m_req_i  in  4  per-master request, bit n = master n; level, held until ack/err.
- m_sel_i  in  16  per-master address[31:28]; master n at [4n+3:4n].
- s_ack_i  in  1  completion from the currently selected slave.
- grant_o  out  2  index of the granted master (registered).
- grant_valid_o  out  1  grant_o and slave_sel_o are valid; bus mux enabled.
- slave_sel_o  out  4  decoded slave index of the granted master (registered).
- m_ack_o  out  4  one-cycle, one-hot completion pulse to the granted master.
- m_err_o  out  4  one-cycle, one-hot error pulse (bad slave or timeout).
- hold_flag_o  out  1  pipeline stall request to the core.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, grant_o=2'd1, grant_valid_o=0, slave_sel_o=0, m_ack_o=0, m_err_o=0, timeout count=0.
  - Round-robin pointer=0.
  - Reset asserted mid-transaction aborts it: no ack/err pulse is issued.
- States: IDLE, BUSY, ERR, DONE.
- IDLE:
  - If m_req_i!=0, pick the winner by round-robin: the first set bit scanning upward from pointer, wrapping 3->0.
  - Register grant_o=winner and slave_sel_o=m_sel_i[winner].
  - If the selected slave < NUM_SLAVES: grant_valid_o=1, go to BUSY. Otherwise grant_valid_o=0, go to ERR.
  - Latency: request seen in cycle N -> grant_valid_o=1 in cycle N+1.
- BUSY:
  - The grant is locked. Changes to m_req_i or m_sel_i are ignored until completion; a master dropping its req does not abort.
  - The counter increments each cycle. On s_ack_i=1: grant_valid_o<=0, m_ack_o[grant]<=1, go to DONE.
  - If count==TIMEOUT-1 and s_ack_i=0: grant_valid_o<=0, m_err_o[grant]<=1, go to DONE.
  - s_ack_i on the timeout cycle counts as success; ack wins.
- ERR: m_err_o[grant]<=1 for one cycle, go to DONE.
- DONE:
  - Pulses are high during this cycle only.
  - Pointer<=(grant_o+1) mod 4; counter cleared; go to IDLE.
  - Minimum back-to-back spacing: 3 cycles from grant to grant.
- s_ack_i outside BUSY is ignored.
- hold_flag_o (combinational) = (m_req_i & 4'b1101)!=0 OR (state!=IDLE AND grant_o!=1). Master 1 (instruction fetch) alone never stalls the pipeline.
- grant_o holds its last value when grant_valid_o=0. The bus mux must gate on grant_valid_o.

Decomposition:
- Shared package / rooth_defines.v holds:
  - state encodings (ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_ERR=2'd2, ARB_DONE=2'd3);
  - master index constants (M_DATA=0, M_INST=1, M_JTAG=2, M_OTHER=3);
  - the slave field position [31:28].
- One sub-module: rr_pick4. It is combinational; given req[3:0] and ptr[1:0] it returns winner[1:0] and any. It is reused by future DMA arbitration.

Test Plan:
- Single request: m_req_i=4'b0001, m_sel_i[3:0]=4'h2, s_ack_i at the 3rd BUSY cycle -> grant_valid_o=1 one cycle after req with grant_o=0, slave_sel_o=2; m_ack_o=4'b0001 for exactly one cycle; hold_flag_o=1 throughout.
- Round-robin fairness: m_req_i=4'b1111 held, slave ack 1 cycle after each grant -> grant order 0,1,2,3,0; no master granted twice before the others.
- Bad slave: m_req_i=4'b0100, m_sel_i[11:8]=4'h9 -> grant_valid_o never 1; m_err_o=4'b0100 pulse 2 cycles after req.
- Timeout: m_req_i=4'b1000, valid slave, s_ack_i held 0 -> m_err_o=4'b1000 after exactly 16 BUSY cycles; then next requester granted.
- Lock and ack/timeout race: master 0 granted; master 3 raises req mid-BUSY and master 0 drops req -> grant_o stays 0 until ack. With s_ack_i on the cycle count==15, m_ack_o fires and m_err_o does not.
- Reset mid-BUSY: rst=1 for 1 cycle -> all outputs at reset values immediately; no ack/err pulse; fresh arbitration starts with pointer=0.

Source files
------------

// File: rtl/bus_arbiter_rr_pkg.sv
// Shared definitions for the RIB bus round-robin arbiter: FSM states, master ids, slave field.
package bus_arbiter_rr_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_ERR  = 2'd2,
    ARB_DONE = 2'd3
  } arb_state_e;

  localparam logic [1:0] M_DATA  = 2'd0;
  localparam logic [1:0] M_INST  = 2'd1;
  localparam logic [1:0] M_JTAG  = 2'd2;
  localparam logic [1:0] M_OTHER = 2'd3;

  localparam int NUM_MASTERS  = 4;
  localparam int SLV_ADDR_MSB = 31;
  localparam int SLV_ADDR_LSB = 28;
  localparam int SLV_W        = SLV_ADDR_MSB - SLV_ADDR_LSB + 1;

  // Instruction fetch alone must never stall the pipeline.
  localparam logic [NUM_MASTERS-1:0] HOLD_MASK =
    (4'b0001 << M_DATA) | (4'b0001 << M_JTAG) | (4'b0001 << M_OTHER);

  function automatic logic [SLV_W-1:0] slave_field(
    input logic [NUM_MASTERS*SLV_W-1:0] sel,
    input logic [1:0]                   idx
  );
    return sel[32'(idx) * SLV_W +: SLV_W];
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of req_i scanning upward from ptr_i, wrapping 3->0.
// Purely combinational; any_o flags that at least one request is present.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [1:0] winner_o,
  output logic       any_o
);

  always_comb begin
    logic [1:0] idx;
    idx      = ptr_i;
    winner_o = ptr_i;
    any_o    = 1'b0;
    // Scan from farthest to nearest so the nearest set bit is the last assignment.
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_i + 2'(i);
      if (req_i[idx]) begin
        winner_o = idx;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin, transaction-locked RIB bus arbiter with slave decode and a hung-slave timeout.
// Grant is registered one cycle after a request; the grant stays locked until ack, timeout or decode error.
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NUM_SLAVES = 6,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  m_req_i,
  input  logic [15:0] m_sel_i,
  input  logic        s_ack_i,
  output logic [1:0]  grant_o,
  output logic        grant_valid_o,
  output logic [3:0]  slave_sel_o,
  output logic [3:0]  m_ack_o,
  output logic [3:0]  m_err_o,
  output logic        hold_flag_o
);

  arb_state_e       state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       ptr_q, ptr_d;
  logic             gvalid_q, gvalid_d;
  logic [SLV_W-1:0] ssel_q, ssel_d;
  logic [3:0]       ack_q, ack_d;
  logic [3:0]       err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       winner;
  logic             any_req;
  logic [SLV_W-1:0] win_sel;
  logic             sel_ok;
  logic             timed_out;

  rr_pick4 u_pick (
    .req_i    (m_req_i),
    .ptr_i    (ptr_q),
    .winner_o (winner),
    .any_o    (any_req)
  );

  assign win_sel   = slave_field(m_sel_i, winner);
  assign sel_ok    = 32'(win_sel) < NUM_SLAVES;
  assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARB_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (any_req) state_d = sel_ok ? ARB_BUSY : ARB_ERR;
      ARB_BUSY: if (s_ack_i || timed_out) state_d = ARB_DONE;
      ARB_ERR:  state_d = ARB_DONE;
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    grant_d  = grant_q;
    ssel_d   = ssel_q;
    gvalid_d = gvalid_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    err_d    = '0;
    case (state_q)
      ARB_IDLE: begin
        if (any_req) begin
          grant_d  = winner;
          ssel_d   = win_sel;
          gvalid_d = sel_ok;
        end
      end
      ARB_BUSY: begin
        cnt_d = cnt_q + 1'b1;
        // Ack on the timeout cycle still counts as success.
        if (s_ack_i) begin
          gvalid_d = 1'b0;
          ack_d    = 4'b0001 << grant_q;
        end else if (timed_out) begin
          gvalid_d = 1'b0;
          err_d    = 4'b0001 << grant_q;
        end
      end
      ARB_ERR:  err_d = 4'b0001 << grant_q;
      ARB_DONE: begin
        ptr_d = grant_q + 2'd1;
        cnt_d = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q  <= M_INST;
      ssel_q   <= '0;
      gvalid_q <= 1'b0;
      ptr_q    <= 2'd0;
      cnt_q    <= '0;
      ack_q    <= '0;
      err_q    <= '0;
    end else begin
      grant_q  <= grant_d;
      ssel_q   <= ssel_d;
      gvalid_q <= gvalid_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
    end
  end

  assign grant_o       = grant_q;
  assign grant_valid_o = gvalid_q;
  assign slave_sel_o   = ssel_q;
  assign m_ack_o       = ack_q;
  assign m_err_o       = err_q;
  assign hold_flag_o   = (|(m_req_i & HOLD_MASK)) || ((state_q != ARB_IDLE) && (grant_q != M_INST));

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: vector table, directed corner sequences, random vs timeline model.
module tb_bus_arbiter_rr;

  localparam int TO  = 16;
  localparam int NSL = 6;
  localparam int BIG = 32'h3fff_ffff;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  m_req_i;
  logic [15:0] m_sel_i;
  logic        s_ack_i;
  logic [1:0]  grant_o;
  logic        grant_valid_o;
  logic [3:0]  slave_sel_o;
  logic [3:0]  m_ack_o;
  logic [3:0]  m_err_o;
  logic        hold_flag_o;

  bus_arbiter_rr #(.NUM_SLAVES(NSL), .TIMEOUT(TO), .CNT_W(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .m_req_i       (m_req_i),
    .m_sel_i       (m_sel_i),
    .s_ack_i       (s_ack_i),
    .grant_o       (grant_o),
    .grant_valid_o (grant_valid_o),
    .slave_sel_o   (slave_sel_o),
    .m_ack_o       (m_ack_o),
    .m_err_o       (m_err_o),
    .hold_flag_o   (hold_flag_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  // Timeline model: cycle numbers at which the arbiter is next free, the grant becomes visible, and a pulse lands.
  int         mdl_ptr, mdl_grant, mdl_sel;
  bit         mdl_open;
  int         mdl_busy_from, mdl_idle_from, mdl_pulse_cyc;
  logic [3:0] mdl_ackm, mdl_errm;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    mdl_ptr       = 0;
    mdl_grant     = 1;
    mdl_sel       = 0;
    mdl_open      = 1'b0;
    mdl_busy_from = 0;
    mdl_idle_from = 0;
    mdl_pulse_cyc = -1;
    mdl_ackm      = '0;
    mdl_errm      = '0;
  endtask

  // One clock: drive inputs, compare all outputs with the model, then advance the model.
  task automatic step(input logic [3:0] req, input logic [15:0] sel, input logic ack);
    int         w;
    int         k;
    logic [3:0] f;
    @(posedge clk);
    #1;
    m_req_i = req;
    m_sel_i = sel;
    s_ack_i = ack;
    #1;
    check("gvalid", grant_valid_o, int'(mdl_open && cyc >= mdl_busy_from));
    check("grant", grant_o, mdl_grant);
    check("slave_sel", slave_sel_o, mdl_sel);
    check("ack", m_ack_o, (cyc == mdl_pulse_cyc) ? mdl_ackm : 4'h0);
    check("err", m_err_o, (cyc == mdl_pulse_cyc) ? mdl_errm : 4'h0);
    check("hold", hold_flag_o, int'(((req & 4'b1101) != 0) || (cyc < mdl_idle_from && mdl_grant != 1)));
    if (cyc >= mdl_idle_from && req != 0) begin
      w = -1;
      for (int i = 0; i < 4; i++)
        if (w < 0 && req[(mdl_ptr + i) % 4]) w = (mdl_ptr + i) % 4;
      f         = sel[4*w +: 4];
      mdl_grant = w;
      mdl_sel   = f;
      mdl_ptr   = (w + 1) % 4;
      if (f < NSL) begin
        mdl_open      = 1'b1;
        mdl_busy_from = cyc + 1;
        mdl_idle_from = BIG;
      end else begin
        mdl_pulse_cyc = cyc + 2;
        mdl_ackm      = 4'h0;
        mdl_errm      = 4'b0001 << w;
        mdl_idle_from = cyc + 3;
      end
    end else if (mdl_open && cyc >= mdl_busy_from) begin
      k = cyc - mdl_busy_from;
      if (ack || k == TO - 1) begin
        mdl_open      = 1'b0;
        mdl_pulse_cyc = cyc + 1;
        mdl_ackm      = ack ? (4'b0001 << mdl_grant) : 4'h0;
        mdl_errm      = ack ? 4'h0 : (4'b0001 << mdl_grant);
        mdl_idle_from = cyc + 2;
      end
    end
  endtask

  // One-cycle async reset; outputs must take reset values without waiting for a clock edge.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    m_req_i = '0;
    m_sel_i = '0;
    s_ack_i = 1'b0;
    #1;
    check("rst_gvalid", grant_valid_o, 0);
    check("rst_grant", grant_o, 1);
    check("rst_sel", slave_sel_o, 0);
    check("rst_ack", m_ack_o, 0);
    check("rst_err", m_err_o, 0);
    check("rst_hold", hold_flag_o, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wait_grant(input logic [3:0] req, input logic [15:0] sel);
    int n = 0;
    do begin
      step(req, sel, 1'b0);
      n++;
    end while (!grant_valid_o && n < 12);
    check("wait_grant", grant_valid_o, 1);
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] sel;
    logic        ack;
    logic        gv;
    logic [1:0]  gnt;
    logic [3:0]  ssel;
    logic [3:0]  acko;
    logic [3:0]  erro;
    logic        hold;
  } vec_t;

  vec_t tbl [10];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int busy;
    int n;
    rst     = 1'b1;
    m_req_i = '0;
    m_sel_i = '0;
    s_ack_i = 1'b0;
    model_reset();

    // Single request to slave 2 acked in 3rd BUSY cycle, then a bad-slave request from master 2.
    tbl[0] = '{4'b0001, 16'h0002, 1'b0, 1'b0, 2'd1, 4'h0, 4'h0, 4'h0, 1'b1};
    tbl[1] = '{4'b0001, 16'h0002, 1'b0, 1'b1, 2'd0, 4'h2, 4'h0, 4'h0, 1'b1};
    tbl[2] = '{4'b0001, 16'h0002, 1'b0, 1'b1, 2'd0, 4'h2, 4'h0, 4'h0, 1'b1};
    tbl[3] = '{4'b0001, 16'h0002, 1'b1, 1'b1, 2'd0, 4'h2, 4'h0, 4'h0, 1'b1};
    tbl[4] = '{4'b0000, 16'h0002, 1'b0, 1'b0, 2'd0, 4'h2, 4'h1, 4'h0, 1'b1};
    tbl[5] = '{4'b0000, 16'h0002, 1'b0, 1'b0, 2'd0, 4'h2, 4'h0, 4'h0, 1'b0};
    tbl[6] = '{4'b0100, 16'h0900, 1'b0, 1'b0, 2'd0, 4'h2, 4'h0, 4'h0, 1'b1};
    tbl[7] = '{4'b0100, 16'h0900, 1'b0, 1'b0, 2'd2, 4'h9, 4'h0, 4'h0, 1'b1};
    tbl[8] = '{4'b0000, 16'h0900, 1'b0, 1'b0, 2'd2, 4'h9, 4'h0, 4'h4, 1'b1};
    tbl[9] = '{4'b0000, 16'h0900, 1'b0, 1'b0, 2'd2, 4'h9, 4'h0, 4'h0, 1'b0};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].req, tbl[i].sel, tbl[i].ack);
      check($sformatf("tbl%0d_gv", i), grant_valid_o, tbl[i].gv);
      check($sformatf("tbl%0d_grant", i), grant_o, tbl[i].gnt);
      check($sformatf("tbl%0d_sel", i), slave_sel_o, tbl[i].ssel);
      check($sformatf("tbl%0d_ack", i), m_ack_o, tbl[i].acko);
      check($sformatf("tbl%0d_err", i), m_err_o, tbl[i].erro);
      check($sformatf("tbl%0d_hold", i), hold_flag_o, tbl[i].hold);
    end

    // Round-robin fairness with all four masters requesting.
    do_reset();
    for (int g = 0; g < 5; g++) begin
      wait_grant(4'hF, 16'h1111);
      check("rr_grant", grant_o, g % 4);
      step(4'hF, 16'h1111, 1'b1);
    end

    // Timeout: exactly TO BUSY cycles, then error pulse; next requester is served.
    do_reset();
    wait_grant(4'b1000, 16'h3000);
    busy = 0;
    n    = 0;
    while (grant_valid_o && n < 40) begin
      busy++;
      step(4'b1000, 16'h3000, 1'b0);
      n++;
    end
    check("to_busy_cycles", busy, TO);
    check("to_err", m_err_o, 4'b1000);
    check("to_no_ack", m_ack_o, 4'b0000);
    wait_grant(4'b1001, 16'h3003);
    check("to_next_grant", grant_o, 0);

    // Lock plus ack/timeout race: requests change mid-BUSY, ack lands on the last allowed cycle.
    do_reset();
    wait_grant(4'b0001, 16'h0002);
    for (int i = 1; i < TO - 1; i++) step(4'b1000, 16'h2002, 1'b0);
    check("lock_grant", grant_o, 0);
    check("lock_gv", grant_valid_o, 1);
    step(4'b1000, 16'h2002, 1'b1);
    step(4'b1000, 16'h2002, 1'b0);
    check("race_ack", m_ack_o, 4'b0001);
    check("race_err", m_err_o, 4'b0000);
    wait_grant(4'b1000, 16'h2002);
    check("race_next_grant", grant_o, 3);

    // Reset in the middle of a transaction, with the pointer advanced beforehand.
    do_reset();
    wait_grant(4'b0010, 16'h0010);
    step(4'b0010, 16'h0010, 1'b1);
    step(4'b0000, 16'h0010, 1'b0);
    wait_grant(4'b0100, 16'h0200);
    check("pre_rst_grant", grant_o, 2);
    step(4'b0100, 16'h0200, 1'b0);
    do_reset();
    step(4'b0000, 16'h0000, 1'b0);
    check("rst_no_ack", m_ack_o, 0);
    check("rst_no_err", m_err_o, 0);
    wait_grant(4'b0111, 16'h0111);
    check("rst_ptr_grant", grant_o, 0);

    // Random traffic against the model, with occasional resets.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0]  r;
      logic [15:0] s;
      logic        a;
      if ($urandom_range(0, 399) == 0) do_reset();
      r = 4'($urandom_range(0, 15));
      for (int j = 0; j < 4; j++) s[4*j +: 4] = 4'($urandom_range(0, 7));
      a = ($urandom_range(0, 9) == 0);
      step(r, s, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
